// File: rtl/usb_ep_router_if.sv
// ============================================================================
// usb_ep_router_if : engine token/handshake and CPU control-port signals
// Revision 1.0
// ============================================================================
`default_nettype none

interface usb_ep_router_if;
  logic        txn_start;
  logic [3:0]  txn_ep;
  logic        txn_dir_in;
  logic        txn_setup;
  logic        txn_end;
  logic        txn_success;
  logic [6:0]  txn_cnt;
  logic        txn_toggle;
  logic [1:0]  txn_handshake;
  logic        txn_in_valid;
  logic [4:0]  cpu_addr;
  logic        cpu_wr_strobe;
  logic [15:0] cpu_wr_data;
  logic        cpu_wr_ready;
  logic [15:0] cpu_rd_data;

  modport master (
    output txn_start, txn_ep, txn_dir_in, txn_setup, txn_end, txn_success, txn_cnt,
    output cpu_addr, cpu_wr_strobe, cpu_wr_data,
    input  txn_toggle, txn_handshake, txn_in_valid, cpu_wr_ready, cpu_rd_data
  );

  modport slave (
    input  txn_start, txn_ep, txn_dir_in, txn_setup, txn_end, txn_success, txn_cnt,
    input  cpu_addr, cpu_wr_strobe, cpu_wr_data,
    output txn_toggle, txn_handshake, txn_in_valid, cpu_wr_ready, cpu_rd_data
  );
endinterface

`default_nettype wire

// File: rtl/usb_ep_router.sv
// ============================================================================
// usb_ep_router : routes transaction engine and CPU control port to endpoints
// Revision 1.0
// ============================================================================
`default_nettype none

module usb_ep_router #(
  parameter int NUM_EP = 4
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  usb_ep_router_if.slave             bus_if,
  output logic                       ep_dir_in_o,
  output logic                       ep_setup_o,
  output logic [6:0]                 ep_cnt_o,
  output logic [NUM_EP-1:0]          ep_success_o,
  input  wire logic [NUM_EP-1:0]     ep_toggle_i,
  input  wire logic [2*NUM_EP-1:0]   ep_handshake_i,
  input  wire logic [NUM_EP-1:0]     ep_in_data_valid_i,
  output logic [NUM_EP-1:0]          ep_ctrl_dir_in_o,
  output logic [NUM_EP-1:0]          ep_ctrl_wr_strobe_o,
  output logic [15:0]                ep_ctrl_wr_data_o,
  input  wire logic [16*NUM_EP-1:0]  ep_ctrl_rd_data_i
);

  localparam logic       c_ST_IDLE   = 1'b0;
  localparam logic       c_ST_ACTIVE = 1'b1;
  localparam logic [4:0] c_NUM_EP    = 5'(NUM_EP);

  logic        state_q, state_d;
  logic [3:0]  sel_ep_q;
  logic        sel_dir_q, sel_setup_q, sel_valid_q;

  logic        pend_valid_q;
  logic [4:0]  pend_addr_q;
  logic [15:0] pend_data_q;
  logic [NUM_EP-1:0] wr_stb_q;
  logic [15:0] wr_data_q;
  logic        wr_dir_q;

  logic        w_active, w_route;
  logic [3:0]  w_wr_tgt;
  logic        w_wr_in_range, w_wr_accept, w_wr_defer, w_wr_issue;
  logic [NUM_EP-1:0] w_wr_onehot, w_pend_onehot;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= c_ST_IDLE;
      sel_ep_q    <= 4'd0;
      sel_dir_q   <= 1'b0;
      sel_setup_q <= 1'b0;
      sel_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (bus_if.txn_start) begin
        sel_ep_q    <= bus_if.txn_ep;
        sel_dir_q   <= bus_if.txn_dir_in;
        sel_setup_q <= bus_if.txn_setup;
        sel_valid_q <= ({1'b0, bus_if.txn_ep} < c_NUM_EP);
      end
    end
  end

  // A restart in ACTIVE wins over a coincident end: the new token is live.
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE:   if (bus_if.txn_start) state_d = c_ST_ACTIVE;
      c_ST_ACTIVE: begin
        if (bus_if.txn_start)    state_d = c_ST_ACTIVE;
        else if (bus_if.txn_end) state_d = c_ST_IDLE;
      end
      default:     state_d = c_ST_IDLE;
    endcase
  end

  assign w_active = (state_q == c_ST_ACTIVE);
  assign w_route  = w_active & sel_valid_q;

  always_comb begin
    bus_if.txn_toggle    = 1'b0;
    bus_if.txn_handshake = 2'b01;
    bus_if.txn_in_valid  = 1'b0;
    ep_success_o         = '0;
    ep_dir_in_o          = w_active & sel_dir_q;
    ep_setup_o           = w_active & sel_setup_q;
    for (int i = 0; i < NUM_EP; i++) begin
      if (w_route && (sel_ep_q == 4'(i))) begin
        bus_if.txn_toggle    = ep_toggle_i[i];
        bus_if.txn_handshake = ep_handshake_i[2*i +: 2];
        bus_if.txn_in_valid  = ep_in_data_valid_i[i];
        ep_success_o[i]      = bus_if.txn_end & bus_if.txn_success;
      end
    end
  end

  assign ep_cnt_o = bus_if.txn_cnt;

  // ---------------------------------------------------------------- CPU path
  assign w_wr_tgt      = bus_if.cpu_addr[4:1];
  assign w_wr_in_range = ({1'b0, w_wr_tgt} < c_NUM_EP);
  assign w_wr_accept   = bus_if.cpu_wr_strobe & bus_if.cpu_wr_ready;
  // Hold back writes aimed at the endpoint that is mid-transaction.
  assign w_wr_defer    = w_wr_accept & w_wr_in_range & w_route &
                         (w_wr_tgt == sel_ep_q) & ~bus_if.txn_end;
  assign w_wr_issue    = w_wr_accept & w_wr_in_range & ~w_wr_defer;

  generate
    for (genvar gi = 0; gi < NUM_EP; gi++) begin : g_ep
      assign w_wr_onehot[gi]      = (w_wr_tgt == 4'(gi));
      assign w_pend_onehot[gi]    = (pend_addr_q[4:1] == 4'(gi));
      assign ep_ctrl_dir_in_o[gi] = wr_stb_q[gi] ? wr_dir_q : bus_if.cpu_addr[0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid_q <= 1'b0;
      pend_addr_q  <= 5'd0;
      pend_data_q  <= 16'd0;
      wr_stb_q     <= '0;
      wr_data_q    <= 16'd0;
      wr_dir_q     <= 1'b0;
    end else begin
      wr_stb_q <= '0;
      if (pend_valid_q && bus_if.txn_end) begin
        wr_stb_q     <= w_pend_onehot;
        wr_data_q    <= pend_data_q;
        wr_dir_q     <= pend_addr_q[0];
        pend_valid_q <= 1'b0;
      end else if (w_wr_issue) begin
        wr_stb_q  <= w_wr_onehot;
        wr_data_q <= bus_if.cpu_wr_data;
        wr_dir_q  <= bus_if.cpu_addr[0];
      end
      if (w_wr_defer) begin
        pend_valid_q <= 1'b1;
        pend_addr_q  <= bus_if.cpu_addr;
        pend_data_q  <= bus_if.cpu_wr_data;
      end
    end
  end

  assign bus_if.cpu_wr_ready = ~pend_valid_q;
  assign ep_ctrl_wr_strobe_o = wr_stb_q;
  assign ep_ctrl_wr_data_o   = wr_data_q;

  always_comb begin
    bus_if.cpu_rd_data = 16'd0;
    for (int i = 0; i < NUM_EP; i++) begin
      if (w_wr_tgt == 4'(i)) bus_if.cpu_rd_data = ep_ctrl_rd_data_i[16*i +: 16];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_usb_ep_router.sv
// ============================================================================
// tb_usb_ep_router : directed bench with success/strobe scoreboard
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_usb_ep_router;
  logic        clk;
  logic        rst;
  logic        ep_dir_in, ep_setup;
  logic [6:0]  ep_cnt;
  logic [3:0]  ep_success;
  logic [3:0]  ep_toggle;
  logic [7:0]  ep_handshake;
  logic [3:0]  ep_in_data_valid;
  logic [3:0]  ep_ctrl_dir_in;
  logic [3:0]  ep_ctrl_wr_strobe;
  logic [15:0] ep_ctrl_wr_data;
  logic [63:0] ep_ctrl_rd_data;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0]  stb;
    logic [15:0] data;
    logic        dir;
  } wr_exp_t;

  wr_exp_t    wr_q[$];
  logic [3:0] succ_q[$];
  wr_exp_t    mon_w;
  logic [3:0] mon_s;

  usb_ep_router_if bus_if ();

  usb_ep_router #(.NUM_EP(4)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .bus_if              (bus_if),
    .ep_dir_in_o         (ep_dir_in),
    .ep_setup_o          (ep_setup),
    .ep_cnt_o            (ep_cnt),
    .ep_success_o        (ep_success),
    .ep_toggle_i         (ep_toggle),
    .ep_handshake_i      (ep_handshake),
    .ep_in_data_valid_i  (ep_in_data_valid),
    .ep_ctrl_dir_in_o    (ep_ctrl_dir_in),
    .ep_ctrl_wr_strobe_o (ep_ctrl_wr_strobe),
    .ep_ctrl_wr_data_o   (ep_ctrl_wr_data),
    .ep_ctrl_rd_data_i   (ep_ctrl_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: success pulses and control-write strobes sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (ep_success !== 4'b0000) begin
        if (succ_q.size() == 0) check("success_unexpected", 32'(ep_success), 32'd0);
        else begin
          mon_s = succ_q.pop_front();
          check("success", 32'(ep_success), 32'(mon_s));
        end
      end
      if (ep_ctrl_wr_strobe !== 4'b0000) begin
        if (wr_q.size() == 0) check("strobe_unexpected", 32'(ep_ctrl_wr_strobe), 32'd0);
        else begin
          mon_w = wr_q.pop_front();
          check("strobe", 32'(ep_ctrl_wr_strobe), 32'(mon_w.stb));
          check("strobe_data", 32'(ep_ctrl_wr_data), 32'(mon_w.data));
          check("strobe_dir", 32'(ep_ctrl_dir_in & mon_w.stb),
                32'(mon_w.dir ? mon_w.stb : 4'b0000));
        end
      end
    end
  end

  initial begin
    rst                  = 1'b1;
    bus_if.txn_start     = 1'b0;
    bus_if.txn_ep        = 4'd0;
    bus_if.txn_dir_in    = 1'b0;
    bus_if.txn_setup     = 1'b0;
    bus_if.txn_end       = 1'b0;
    bus_if.txn_success   = 1'b0;
    bus_if.txn_cnt       = 7'd0;
    bus_if.cpu_addr      = 5'd0;
    bus_if.cpu_wr_strobe = 1'b0;
    bus_if.cpu_wr_data   = 16'd0;
    ep_toggle            = 4'b0100;
    ep_handshake         = {2'b10, 2'b00, 2'b11, 2'b10};
    ep_in_data_valid     = 4'b1011;
    ep_ctrl_rd_data      = {16'h3333, 16'h2222, 16'h1111, 16'hA0A0};
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_wr_ready", 32'(bus_if.cpu_wr_ready), 32'd1);
    check("rst_success", 32'(ep_success), 32'd0);
    check("rst_strobe", 32'(ep_ctrl_wr_strobe), 32'd0);
    check("rst_wr_data", 32'(ep_ctrl_wr_data), 32'd0);
    check("rst_dir_setup", 32'({ep_dir_in, ep_setup}), 32'd0);
    check("rst_txn_out", 32'({bus_if.txn_toggle, bus_if.txn_handshake, bus_if.txn_in_valid}),
          32'b0010);

    // IN token on ep 2
    bus_if.txn_start = 1'b1; bus_if.txn_ep = 4'd2; bus_if.txn_dir_in = 1'b1;
    bus_if.txn_cnt = 7'h2A;
    #1;
    check("idle_handshake", 32'(bus_if.txn_handshake), 32'b01);
    check("ep_cnt", 32'(ep_cnt), 32'h2A);
    tick();
    bus_if.txn_start = 1'b0;
    #1;
    check("ep2_handshake", 32'(bus_if.txn_handshake), 32'b00);
    check("ep2_toggle", 32'(bus_if.txn_toggle), 32'd1);
    check("ep2_in_valid", 32'(bus_if.txn_in_valid), 32'd0);
    check("ep2_dir_in", 32'(ep_dir_in), 32'd1);
    bus_if.txn_end = 1'b1; bus_if.txn_success = 1'b1;
    succ_q.push_back(4'b0100);
    #1;
    check("ep2_success_now", 32'(ep_success), 32'b0100);
    tick();
    bus_if.txn_end = 1'b0; bus_if.txn_success = 1'b0;
    #1;
    check("ep2_success_gone", 32'(ep_success), 32'd0);
    check("idle_dir_in", 32'(ep_dir_in), 32'd0);

    // out-of-range token ep 7
    ep_handshake = 8'h00; ep_in_data_valid = 4'hF;
    bus_if.txn_start = 1'b1; bus_if.txn_ep = 4'd7; bus_if.txn_dir_in = 1'b0;
    tick();
    bus_if.txn_start = 1'b0;
    #1;
    check("ep7_handshake", 32'(bus_if.txn_handshake), 32'b01);
    check("ep7_in_valid", 32'(bus_if.txn_in_valid), 32'd0);
    bus_if.txn_end = 1'b1; bus_if.txn_success = 1'b1;
    #1;
    check("ep7_no_success", 32'(ep_success), 32'd0);
    tick();
    bus_if.txn_end = 1'b0; bus_if.txn_success = 1'b0;
    ep_handshake = {2'b10, 2'b00, 2'b11, 2'b10}; ep_in_data_valid = 4'b1011;

    // deferred write to in-flight ep 1
    bus_if.txn_start = 1'b1; bus_if.txn_ep = 4'd1; bus_if.txn_dir_in = 1'b0;
    tick();
    bus_if.txn_start = 1'b0;
    #1;
    check("ep1_handshake", 32'(bus_if.txn_handshake), 32'b11);
    check("ep1_in_valid", 32'(bus_if.txn_in_valid), 32'd1);
    bus_if.cpu_addr = 5'b00010; bus_if.cpu_wr_data = 16'h0010; bus_if.cpu_wr_strobe = 1'b1;
    tick();
    bus_if.cpu_wr_strobe = 1'b0; bus_if.cpu_wr_data = 16'hFFFF;
    #1;
    check("defer_ready_low", 32'(bus_if.cpu_wr_ready), 32'd0);
    tick();
    tick();
    check("defer_no_strobe", 32'(ep_ctrl_wr_strobe), 32'd0);
    bus_if.txn_end = 1'b1; bus_if.txn_success = 1'b1;
    succ_q.push_back(4'b0010);
    wr_q.push_back('{stb: 4'b0010, data: 16'h0010, dir: 1'b0});
    tick();
    bus_if.txn_end = 1'b0; bus_if.txn_success = 1'b0;
    #1;
    check("release_ready", 32'(bus_if.cpu_wr_ready), 32'd1);
    check("release_strobe", 32'(ep_ctrl_wr_strobe), 32'b0010);
    check("release_data", 32'(ep_ctrl_wr_data), 32'h0010);
    tick();

    // write to another endpoint while ep 1 active
    bus_if.txn_start = 1'b1; bus_if.txn_ep = 4'd1;
    tick();
    bus_if.txn_start = 1'b0;
    bus_if.cpu_addr = 5'b00111; bus_if.cpu_wr_data = 16'hABCD; bus_if.cpu_wr_strobe = 1'b1;
    wr_q.push_back('{stb: 4'b1000, data: 16'hABCD, dir: 1'b1});
    tick();
    bus_if.cpu_wr_strobe = 1'b0; bus_if.cpu_addr = 5'b00000;
    #1;
    check("other_strobe", 32'(ep_ctrl_wr_strobe), 32'b1000);
    check("other_dir_in", 32'(ep_ctrl_dir_in), 32'b1000);
    bus_if.txn_end = 1'b1;
    tick();
    bus_if.txn_end = 1'b0;

    // abandoned token: only the restarted endpoint gets success
    bus_if.txn_start = 1'b1; bus_if.txn_ep = 4'd0;
    tick();
    bus_if.txn_ep = 4'd2;
    tick();
    bus_if.txn_start = 1'b0;
    bus_if.txn_end = 1'b1; bus_if.txn_success = 1'b1;
    succ_q.push_back(4'b0100);
    #1;
    check("restart_success", 32'(ep_success), 32'b0100);
    tick();
    bus_if.txn_end = 1'b0; bus_if.txn_success = 1'b0;

    // read path incl. out-of-range address
    bus_if.cpu_addr = 5'b00100;
    #1;
    check("rd_ep2", 32'(bus_if.cpu_rd_data), 32'h2222);
    bus_if.cpu_addr = 5'b00001;
    #1;
    check("rd_ep0", 32'(bus_if.cpu_rd_data), 32'hA0A0);
    bus_if.cpu_addr = 5'b01010;
    #1;
    check("rd_ep5_zero", 32'(bus_if.cpu_rd_data), 32'd0);

    // out-of-range write is dropped (scoreboard flags any strobe)
    bus_if.cpu_addr = 5'b01101; bus_if.cpu_wr_data = 16'h6666; bus_if.cpu_wr_strobe = 1'b1;
    tick();
    bus_if.cpu_wr_strobe = 1'b0;
    tick();
    check("drop_no_strobe", 32'(ep_ctrl_wr_strobe), 32'd0);

    // pending write discarded by reset
    bus_if.txn_start = 1'b1; bus_if.txn_ep = 4'd3;
    tick();
    bus_if.txn_start = 1'b0;
    bus_if.cpu_addr = 5'b00110; bus_if.cpu_wr_data = 16'h7777; bus_if.cpu_wr_strobe = 1'b1;
    tick();
    bus_if.cpu_wr_strobe = 1'b0;
    #1;
    check("pend_ready_low", 32'(bus_if.cpu_wr_ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(bus_if.cpu_wr_ready), 32'd1);
    check("post_rst_handshake", 32'(bus_if.txn_handshake), 32'b01);
    bus_if.txn_end = 1'b1;
    tick();
    bus_if.txn_end = 1'b0;
    tick();
    check("post_rst_no_strobe", 32'(ep_ctrl_wr_strobe), 32'd0);

    // write in the txn_end cycle to the latched endpoint is not deferred
    bus_if.txn_start = 1'b1; bus_if.txn_ep = 4'd1;
    tick();
    bus_if.txn_start = 1'b0;
    bus_if.txn_end = 1'b1; bus_if.txn_success = 1'b1;
    bus_if.cpu_addr = 5'b00011; bus_if.cpu_wr_data = 16'h5555; bus_if.cpu_wr_strobe = 1'b1;
    succ_q.push_back(4'b0010);
    wr_q.push_back('{stb: 4'b0010, data: 16'h5555, dir: 1'b1});
    tick();
    bus_if.txn_end = 1'b0; bus_if.txn_success = 1'b0; bus_if.cpu_wr_strobe = 1'b0;
    #1;
    check("end_cycle_ready", 32'(bus_if.cpu_wr_ready), 32'd1);
    check("end_cycle_strobe", 32'(ep_ctrl_wr_strobe), 32'b0010);

    tick();
    tick();
    check("succ_q_empty", 32'(succ_q.size()), 32'd0);
    check("wr_q_empty", 32'(wr_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
